// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and defaults for the line buffer controller.
package line_buf_pkg;

  localparam int unsigned LINE_SIZE_DEF = 1440;
  localparam int unsigned NUM_LINES_DEF = 5;

  typedef logic [2:0]  slot_t;
  typedef logic [10:0] px_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_READ
  } rd_state_t;

  function automatic slot_t slot_inc(input slot_t s, input int unsigned n);
    return (32'(s) == n - 1) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_slot_tracker.sv
// Full-flag vector and committed-slot level for the line buffer.
module slot_tracker
  import line_buf_pkg::*;
#(
  parameter int unsigned NUM_LINES = NUM_LINES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  slot_t                set_slot,
  input  logic                 clr_en,
  input  slot_t                clr_slot,
  output logic [NUM_LINES-1:0] full,
  output logic [2:0]           level
);

  logic [NUM_LINES-1:0] set_mask;
  logic [NUM_LINES-1:0] clr_mask;

  assign set_mask = {{(NUM_LINES-1){1'b0}}, set_en} << set_slot;
  assign clr_mask = {{(NUM_LINES-1){1'b0}}, clr_en} << clr_slot;

  // commit sets a flag, free clears one; simultaneous commit+free keeps level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full  <= '0;
      level <= '0;
    end else begin
      full <= (full | set_mask) & ~clr_mask;
      if (set_en && !clr_en)
        level <= level + 3'd1;
      else if (clr_en && !set_en)
        level <= level - 3'd1;
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Line buffer controller: write FSM fills slots from the decoder, read FSM
// streams full slots out as Avalon-ST. Define LINE_BUF_CTRL_STATS_EN to add
// saturating drop_count/short_count outputs.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int unsigned LINE_SIZE = LINE_SIZE_DEF,
  parameter int unsigned NUM_LINES = NUM_LINES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_sol,
  input  logic        wr_valid,
  output logic        wr_en,
  output slot_t       wr_slot,
  output px_t         wr_px,
  output logic        rd_en,
  output slot_t       rd_slot,
  output px_t         rd_px,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [2:0]  level,
  output logic        overflow,
  output logic        short_line
`ifdef LINE_BUF_CTRL_STATS_EN
  ,
  output logic [15:0] drop_count,
  output logic [15:0] short_count
`endif
);

  localparam px_t PX_LAST = px_t'(LINE_SIZE - 1);

  wr_state_t            wr_state, wr_next;
  rd_state_t            rd_state, rd_next;
  slot_t                wr_ptr, rd_ptr, rd_ptr_nxt;
  px_t                  wr_cnt, rd_cnt;
  logic [NUM_LINES-1:0] full;
  logic                 admit, commit, free_slot;

  slot_tracker #(.NUM_LINES(NUM_LINES)) u_slot_tracker (
    .clock    (clock),
    .reset    (reset),
    .set_en   (commit),
    .set_slot (wr_ptr),
    .clr_en   (free_slot),
    .clr_slot (rd_ptr),
    .full     (full),
    .level    (level)
  );

  assign admit = (32'(level) + ((wr_state == W_FILL) ? 32'd1 : 32'd0)) < NUM_LINES;

  // write state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  // write next state; a new SOL mid-fill restarts the same slot
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE, W_DROP: if (wr_sol) wr_next = admit ? W_FILL : W_DROP;
      W_FILL:         if (commit) wr_next = W_IDLE;
      default:        wr_next = W_IDLE;
    endcase
  end

  // write outputs
  always_comb begin
    wr_en      = 1'b0;
    overflow   = 1'b0;
    short_line = 1'b0;
    commit     = 1'b0;
    case (wr_state)
      W_IDLE, W_DROP: overflow = wr_sol && !admit;
      W_FILL: begin
        wr_en      = wr_valid;
        short_line = wr_sol;
        commit     = wr_valid && !wr_sol && (wr_cnt == PX_LAST);
      end
      default: ;
    endcase
  end

  // write slot pointer and pixel counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (commit) begin
      wr_ptr <= slot_inc(wr_ptr, NUM_LINES);
      wr_cnt <= '0;
    end else if (wr_state == W_FILL && !wr_sol) begin
      if (wr_valid) wr_cnt <= wr_cnt + px_t'(1);
    end else begin
      wr_cnt <= '0;
    end
  end

  assign wr_slot    = wr_ptr;
  assign wr_px      = wr_cnt;
  assign rd_slot    = rd_ptr;
  assign rd_px      = rd_cnt;
  assign rd_ptr_nxt = slot_inc(rd_ptr, NUM_LINES);

  // read state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  // read next state; stays in R_READ across slots when the next is already full
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (full[rd_ptr]) rd_next = R_READ;
      R_READ: if (free_slot && !full[rd_ptr_nxt]) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // read outputs
  always_comb begin
    rd_en     = (rd_state == R_READ) && (!out_valid || out_ready);
    free_slot = rd_en && (rd_cnt == PX_LAST);
  end

  // read slot pointer and pixel counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else if (rd_en) begin
      if (rd_cnt == PX_LAST) begin
        rd_cnt <= '0;
        rd_ptr <= rd_ptr_nxt;
      end else begin
        rd_cnt <= rd_cnt + px_t'(1);
      end
    end
  end

  // output sideband tracks memory data one cycle after rd_en, held while stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_sop   <= (rd_cnt == '0);
      out_eop   <= (rd_cnt == PX_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end
  end

`ifdef LINE_BUF_CTRL_STATS_EN
  // saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count  <= '0;
      short_count <= '0;
    end else begin
      if (overflow && drop_count != '1)    drop_count  <= drop_count + 16'd1;
      if (short_line && short_count != '1) short_count <= short_count + 16'd1;
    end
  end
`endif

endmodule
